// File: rtl/midi_pkg.sv
// Shared MIDI definitions: receiver state encoding, line constants and the
// 2-of-3 vote helper used by the optional majority-sampling build.
package midi_pkg;

  localparam int MIDI_BAUD  = 31250;
  localparam int OVERSAMPLE = 16;

  // Tick index (within a 16-tick bit period) that sits at mid-bit.
  localparam logic [3:0] MID_TICK = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// Serial line, CPU acknowledge and byte/status outputs of the MIDI receiver.
// The receiver drives the bus through the master modport; the consumer
// (holding register / CPU) uses the slave modport.
interface midi_uart_rx_if #(parameter int WIDTH = 8);

  logic             rxd;
  logic             rd_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             rx_full;
  logic             overrun;
  logic             framing_err;

  modport master (
    input  rxd, rd_ack,
    output data_out, data_valid, rx_full, overrun, framing_err
  );

  modport slave (
    output rxd, rd_ack,
    input  data_out, data_valid, rx_full, overrun, framing_err
  );

endinterface

// File: rtl/midi_baud_tick.sv
// Oversample tick generator: one-clock tick every DIVISOR clocks.
// Shared with the MIDI transmitter.
module midi_baud_tick #(
  parameter int DIVISOR = 2
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIVISOR - 1);

  logic [7:0] count_r;

  // Free-running 0..DIVISOR-1 counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (count_r == LAST) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_r + 8'd1;
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI receive UART: 16x oversampled 8N1, LSB first, one-clock data_valid
// strobe plus rx_full / overrun / framing status for the CPU.
// Build option MIDI_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote of
// ticks 7, 8 and 9; otherwise the tick-8 sample alone is used. Both builds
// decide at tick 9, so latency is identical.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int DIVISOR = 2,
  parameter int WIDTH   = 8
) (
  input logic            clock,
  input logic            reset,
  midi_uart_rx_if.master bus
);

  localparam int         BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic             sync1_r, sync2_r;
  logic             tick_s;
  rx_state_e        state_r, state_next_s;
  logic [3:0]       sample_cnt_r;
  logic [3:0]       pos_s;
  logic [BW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic             s8_r;
  logic             bit_s;
  logic             decide_s;
  logic             cnt_clear_s, shift_en_s, finish_s;
  logic             complete_r, stop_bit_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r, rx_full_r, overrun_r, framing_err_r;

  midi_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.rxd;
      sync2_r <= sync1_r;
    end
  end

  // Index of the current tick within the bit period (detect tick is 0).
  assign pos_s    = sample_cnt_r + 4'd1;
  assign decide_s = tick_s && (pos_s == MID_TICK + 4'd1);

`ifdef MIDI_RX_MAJORITY_EN
  logic s7_r;

  // Capture the tick-7 line sample for the vote.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s7_r <= 1'b1;
    end else if (tick_s && (pos_s == MID_TICK - 4'd1)) begin
      s7_r <= sync2_r;
    end
  end

  assign bit_s = maj3(s7_r, s8_r, sync2_r);
`else
  assign bit_s = s8_r;
`endif

  // Capture the mid-bit (tick-8) line sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s8_r <= 1'b1;
    end else if (tick_s && (pos_s == MID_TICK)) begin
      s8_r <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and datapath control strobes.
  always_comb begin
    state_next_s = state_r;
    cnt_clear_s  = 1'b0;
    shift_en_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !sync2_r) begin
          cnt_clear_s  = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s) begin
          state_next_s = bit_s ? ST_IDLE : ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            state_next_s = ST_STOP;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          finish_s     = 1'b1;
          state_next_s = bit_s ? ST_IDLE : ST_BREAK;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (tick_s && sync2_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sample/bit counters, shift register and the completion pipeline stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      complete_r   <= 1'b0;
      stop_bit_r   <= 1'b1;
    end else begin
      if (cnt_clear_s) begin
        sample_cnt_r <= 4'd0;
        bit_cnt_r    <= '0;
      end else if (tick_s && (state_r != ST_IDLE)) begin
        sample_cnt_r <= sample_cnt_r + 4'd1;
      end
      if (shift_en_s) begin
        shift_r   <= {bit_s, shift_r[WIDTH-1:1]};
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end
      complete_r <= finish_s;
      if (finish_s) begin
        stop_bit_r <= bit_s;
      end
    end
  end

  // Byte delivery and sticky status; an ack in the completion clock retires
  // the old byte so the new one is delivered instead of overrunning.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_r    <= '0;
      data_valid_r  <= 1'b0;
      rx_full_r     <= 1'b0;
      overrun_r     <= 1'b0;
      framing_err_r <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      if (complete_r) begin
        if (rx_full_r && !bus.rd_ack) begin
          overrun_r <= 1'b1;
        end else begin
          data_out_r   <= shift_r;
          data_valid_r <= 1'b1;
          rx_full_r    <= 1'b1;
          overrun_r    <= 1'b0;
        end
        framing_err_r <= !stop_bit_r || (framing_err_r && !(bus.rd_ack && rx_full_r));
      end else if (bus.rd_ack && rx_full_r) begin
        rx_full_r     <= 1'b0;
        overrun_r     <= 1'b0;
        framing_err_r <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.rx_full     = rx_full_r;
  assign bus.overrun     = overrun_r;
  assign bus.framing_err = framing_err_r;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: directed frames at 1 MHz / DIVISOR=2. Expected bytes
// are queued by the stimulus; a negedge monitor pops and compares on every
// data_valid strobe. Status flags are checked directly from the stimulus.
module tb_midi_uart_rx;

  localparam int WIDTH    = 8;
  localparam int DIVISOR  = 2;
  localparam int CLK_HALF = 500;
  localparam int BIT_T    = 32000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  midi_uart_rx_if #(.WIDTH(WIDTH)) bus ();

  midi_uart_rx #(.DIVISOR(DIVISOR), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #CLK_HALF clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected byte.
  always @(negedge clock) begin
    if (!reset && bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: data_out=%0h, no byte expected", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("strobe_data", 32'(bus.data_out), 32'(e));
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int bt, input logic stop);
    bus.rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      #(bt);
    end
    bus.rxd = stop;
    #(bt);
    bus.rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input int bt);
    @(negedge clock);
    send_bits(b, bt, 1'b1);
    idle(4);
  endtask

  task automatic ack();
    @(negedge clock);
    bus.rd_ack = 1'b1;
    @(negedge clock);
    bus.rd_ack = 1'b0;
  endtask

  task automatic flags(input string tag, input logic full, input logic ovr, input logic fe);
    check({tag, "_rx_full"}, 32'(bus.rx_full), 32'(full));
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(ovr));
    check({tag, "_framing"}, 32'(bus.framing_err), 32'(fe));
  endtask

  initial begin
    #(60_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, lat, n;
    bus.rxd    = 1'b1;
    bus.rd_ack = 1'b0;

    // Reset values.
    idle(3);
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_data_valid", 32'(bus.data_valid), 32'h0);
    flags("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    idle(5);

    // Clean note-on status byte.
    exp_q.push_back(8'h90);
    send(8'h90, BIT_T);
    check("b90_data_out", 32'(bus.data_out), 32'h90);
    flags("b90", 1'b1, 1'b0, 1'b0);
    ack();
    flags("b90_ack", 1'b0, 1'b0, 1'b0);

    // Short low glitch on an idle line: no reception.
    @(negedge clock);
    bus.rxd = 1'b0;
    idle(8);
    bus.rxd = 1'b1;
    idle(60);
    flags("glitch", 1'b0, 1'b0, 1'b0);
    check("glitch_data_out", 32'(bus.data_out), 32'h90);

`ifdef MIDI_RX_MAJORITY_EN
    // One-tick spike inside data bit 3 of 0xFF is voted out.
    exp_q.push_back(8'hFF);
    @(negedge clock);
    bus.rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = 1'b1;
      if (i == 3) begin
        #(BIT_T / 2 - 1000);
        bus.rxd = 1'b0;
        #(2000);
        bus.rxd = 1'b1;
        #(BIT_T / 2 - 1000);
      end else begin
        #(BIT_T);
      end
    end
    bus.rxd = 1'b1;
    #(BIT_T);
    idle(4);
    check("spike_data_out", 32'(bus.data_out), 32'hFF);
    ack();
`endif

    // Overrun: second byte dropped, first preserved.
    exp_q.push_back(8'h3C);
    send(8'h3C, BIT_T);
    send(8'h7F, BIT_T);
    check("ovr_data_out", 32'(bus.data_out), 32'h3C);
    flags("ovr", 1'b1, 1'b1, 1'b0);
    ack();
    flags("ovr_ack", 1'b0, 1'b0, 1'b0);

    // Framing error with the line held low (break).
    exp_q.push_back(8'h55);
    @(negedge clock);
    send_bits(8'h55, BIT_T, 1'b0);
    bus.rxd = 1'b0;
    #(2 * BIT_T);
    check("fe_data_out", 32'(bus.data_out), 32'h55);
    flags("fe", 1'b1, 1'b0, 1'b1);
    bus.rxd = 1'b1;
    idle(64);
    ack();
    flags("fe_ack", 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
    send(8'h01, BIT_T);
    check("after_break_data_out", 32'(bus.data_out), 32'h01);
    flags("after_break", 1'b1, 1'b0, 1'b0);

    // Reset during data bit 4 of 0xA5.
    @(negedge clock);
    bus.rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = (i % 2 == 0) ? 1'b1 : 1'b0;
      #(BIT_T);
    end
    bus.rxd = 1'b0;
    #(BIT_T / 2);
    reset = 1'b1;
    #1;
    check("mid_reset_data_out", 32'(bus.data_out), 32'h0);
    check("mid_reset_data_valid", 32'(bus.data_valid), 32'h0);
    flags("mid_reset", 1'b0, 1'b0, 1'b0);
    bus.rxd = 1'b1;
    idle(10);
    reset = 1'b0;
    idle(4);
    exp_q.push_back(8'h12);
    send(8'h12, BIT_T);
    check("post_reset_data_out", 32'(bus.data_out), 32'h12);
    flags("post_reset", 1'b1, 1'b0, 1'b0);
    ack();

    // Baud skew of +3% and -3%.
    exp_q.push_back(8'hC3);
    send(8'hC3, 32960);
    check("skew_plus_data_out", 32'(bus.data_out), 32'hC3);
    flags("skew_plus", 1'b1, 1'b0, 1'b0);
    ack();
    exp_q.push_back(8'hC3);
    send(8'hC3, 31040);
    check("skew_minus_data_out", 32'(bus.data_out), 32'hC3);
    flags("skew_minus", 1'b1, 1'b0, 1'b0);
    ack();

    // rd_ack on the completion clock of a second 0x22: first frame measures
    // the start-to-strobe latency, second frame starts at the same tick phase.
    exp_q.push_back(8'h22);
    @(negedge clock);
    c0  = cyc;
    lat = 0;
    fork
      send_bits(8'h22, BIT_T, 1'b1);
      begin
        n = 0;
        while (bus.data_valid !== 1'b1 && n < 400) begin
          @(negedge clock);
          n++;
        end
        lat = cyc - c0;
      end
    join
    check("calib_strobe_seen", 32'(n < 400), 32'h1);
    idle(4);
    while (((cyc - c0) % 2) != 0) @(negedge clock);
    c1 = cyc;
    exp_q.push_back(8'h22);
    fork
      send_bits(8'h22, BIT_T, 1'b1);
      begin
        n = 0;
        while (cyc < c1 + lat - 1 && n < 400) begin
          @(negedge clock);
          n++;
        end
        bus.rd_ack = 1'b1;
        @(negedge clock);
        bus.rd_ack = 1'b0;
        check("ack_race_data_out", 32'(bus.data_out), 32'h22);
        flags("ack_race", 1'b1, 1'b0, 1'b0);
      end
    join
    idle(4);

    // Every queued byte must have been strobed.
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
